// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared constants, state encoding and byte-merge helper for the timer bank
package timer_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  be
    );
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one down-counter channel: CTRL/PRESET/COUNT/pending plus its IDLE/LOAD/CNT/INT FSM
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_ctrl,
    input  logic             wr_preset,
    input  logic             clr_pend,
    input  logic [WIDTH-1:0] wdata,
    output logic [3:0]       ctrl,
    output logic [WIDTH-1:0] preset,
    output logic [WIDTH-1:0] count,
    output logic             pending,
    output logic             irq
);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       ctrl_eff;
    logic [3:0]       ctrl_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             set_pend;

    // The FSM decides on the CTRL value as it will be after this edge, so an
    // enabling write leaves IDLE on the same edge and a disabling write freezes COUNT.
    assign ctrl_eff = wr_ctrl ? wdata[3:0] : ctrl;

    always_comb begin
        state_nxt = state;
        ctrl_nxt  = ctrl_eff;
        count_nxt = count;
        set_pend  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ctrl_eff[CTRL_EN]) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                count_nxt = preset;
                state_nxt = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_eff[CTRL_EN]) begin
                    state_nxt = ST_IDLE;
                end else if (count <= WIDTH'(1)) begin
                    count_nxt = '0;
                    set_pend  = 1'b1;
                    state_nxt = ST_INT;
                end else begin
                    count_nxt = count - WIDTH'(1);
                end
            end
            ST_INT: begin
                // Reserved MODE encodings fall through to one-shot.
                if (ctrl_eff[CTRL_MODE_LO +: 2] == MODE_RELOAD) begin
                    state_nxt = ctrl_eff[CTRL_EN] ? ST_LOAD : ST_IDLE;
                end else begin
                    ctrl_nxt[CTRL_EN] = 1'b0;
                    state_nxt         = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            ctrl    <= {1'b0, MODE_ONESHOT, 1'b0};
            preset  <= '0;
            count   <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_nxt;
            ctrl    <= ctrl_nxt;
            count   <= count_nxt;
            if (wr_preset) preset <= wdata;
            pending <= set_pend | (pending & ~clr_pend);
        end
    end

    assign irq = pending & ctrl[CTRL_IM];

endmodule

// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - multi-channel timer bank: address decode, byte-enable merge, read mux, IRQ vector
module timer_bank
    import timer_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [29:0]     Addr,
    input  logic            WE,
    input  logic [3:0]      byteen,
    input  logic [31:0]     Din,
    output logic [31:0]     Dout,
    output logic [N_CH-1:0] IRQ
);

    // One extra channel-index bit so the slot just past the last channel
    // decodes as empty instead of aliasing onto channel 0.
    localparam int CH_W = $clog2(N_CH) + 1;

    logic [1:0]       reg_sel;
    logic [CH_W-1:0]  ch_sel;
    logic [31:0]      wdata;
    logic             unused_bits;

    logic [3:0]       ctrl_q    [N_CH];
    logic [WIDTH-1:0] preset_q  [N_CH];
    logic [WIDTH-1:0] count_q   [N_CH];
    logic             pending_q [N_CH];

    assign reg_sel     = Addr[1:0];
    assign ch_sel      = Addr[CH_W+1:2];
    assign unused_bits = ^{Addr[29:CH_W+2], wdata};

    // Partial writes merge into the addressed register's current read value.
    assign wdata = merge_bytes(Dout, Din, byteen);

    always_comb begin
        Dout = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (ch_sel == CH_W'(c)) begin
                case (reg_sel)
                    REG_CTRL:   Dout = 32'(ctrl_q[c]);
                    REG_PRESET: Dout = 32'(preset_q[c]);
                    REG_COUNT:  Dout = 32'(count_q[c]);
                    default:    Dout = 32'(pending_q[c]);
                endcase
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic sel;
        assign sel = WE && (ch_sel == CH_W'(c));

        timer_channel #(
            .WIDTH (WIDTH)
        ) u_channel (
            .clk       (clk),
            .reset     (reset),
            .wr_ctrl   (sel && (reg_sel == REG_CTRL)),
            .wr_preset (sel && (reg_sel == REG_PRESET)),
            .clr_pend  (sel && (reg_sel == REG_STATUS) && byteen[0] && Din[0]),
            .wdata     (wdata[WIDTH-1:0]),
            .ctrl      (ctrl_q[c]),
            .preset    (preset_q[c]),
            .count     (count_q[c]),
            .pending   (pending_q[c]),
            .irq       (IRQ[c])
        );
    end

endmodule

// File: tb/tb_timer_bank.sv
// tb/tb_timer_bank.sv - scoreboard bench for timer_bank with directed scenarios and random register traffic
module tb_timer_bank;

    localparam int N_CH  = 2;
    localparam int WIDTH = 32;

    localparam int PH_IDLE = 0;
    localparam int PH_ARM  = 1;
    localparam int PH_RUN  = 2;
    localparam int PH_DONE = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [29:0]     Addr;
    logic            WE;
    logic [3:0]      byteen;
    logic [31:0]     Din;
    logic [31:0]     Dout;
    logic [N_CH-1:0] IRQ;

    always #5 clk = ~clk;

    timer_bank #(
        .N_CH  (N_CH),
        .WIDTH (WIDTH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .Addr   (Addr),
        .WE     (WE),
        .byteen (byteen),
        .Din    (Din),
        .Dout   (Dout),
        .IRQ    (IRQ)
    );

    int checks = 0;
    int errors = 0;

    logic [33:0] exp_q[$];

    logic [31:0] m_ctrl   [N_CH];
    logic [31:0] m_preset [N_CH];
    logic [31:0] m_count  [N_CH];
    logic        m_pend   [N_CH];
    int          m_ph     [N_CH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [29:0] A(input int ch, input int rg);
        return 30'(ch * 4 + rg);
    endfunction

    function automatic logic [31:0] m_read(input logic [29:0] a);
        int ch;
        ch = int'(a[3:2]);
        if (ch >= N_CH) return 32'h0;
        case (a[1:0])
            2'd0:    return m_ctrl[ch];
            2'd1:    return m_preset[ch];
            2'd2:    return m_count[ch];
            default: return {31'b0, m_pend[ch]};
        endcase
    endfunction

    function automatic logic [1:0] m_irq();
        logic [1:0] v;
        for (int c = 0; c < N_CH; c++) v[c] = m_pend[c] & m_ctrl[c][3];
        return v;
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Reference behaviour at one clock edge, applying the register rules to the inputs now on the bus.
    task automatic m_edge();
        logic [31:0] merged, ctrl_e, cnt;
        logic        sel, en, set, clr;
        int          ph;
        for (int c = 0; c < N_CH; c++) begin
            if (reset) begin
                m_ctrl[c] = 0; m_preset[c] = 0; m_count[c] = 0; m_pend[c] = 0; m_ph[c] = PH_IDLE;
                continue;
            end
            sel    = WE && (int'(Addr[3:2]) == c);
            merged = m_merge(m_read(Addr), Din, byteen);
            ctrl_e = (sel && Addr[1:0] == 2'd0) ? (merged & 32'hF) : m_ctrl[c];
            clr    = sel && Addr[1:0] == 2'd3 && byteen[0] && Din[0];
            en     = ctrl_e[0];
            set    = 1'b0;
            cnt    = m_count[c];
            ph     = m_ph[c];
            case (ph)
                PH_IDLE: if (en) ph = PH_ARM;
                PH_ARM: begin cnt = m_preset[c]; ph = PH_RUN; end
                PH_RUN: begin
                    if (!en) ph = PH_IDLE;
                    else if (cnt <= 1) begin cnt = 0; set = 1'b1; ph = PH_DONE; end
                    else cnt = cnt - 1;
                end
                default: begin
                    if (ctrl_e[2:1] == 2'b01) ph = en ? PH_ARM : PH_IDLE;
                    else begin ctrl_e[0] = 1'b0; ph = PH_IDLE; end
                end
            endcase
            if (sel && Addr[1:0] == 2'd1) m_preset[c] = merged;
            m_ctrl[c]  = ctrl_e;
            m_count[c] = cnt;
            m_pend[c]  = set | (m_pend[c] & ~clr);
            m_ph[c]    = ph;
        end
    endtask

    task automatic step();
        exp_q.push_back({m_irq(), m_read(Addr)});
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
        Addr = a; WE = 1'b1; Din = d; byteen = be;
        step();
        WE = 1'b0; Din = 32'h0; byteen = 4'h0;
    endtask

    task automatic idle(input logic [29:0] a);
        Addr = a; WE = 1'b0;
        step();
    endtask

    task automatic rd_chk(input string name, input logic [29:0] a, input logic [31:0] exp);
        Addr = a; WE = 1'b0;
        #1;
        chk(name, Dout, exp);
    endtask

    task automatic wait_rise(input int c, input int exp_edges, input string name);
        int n;
        n = 0;
        while (IRQ[c] !== 1'b1 && n < 40) begin
            idle(Addr);
            n++;
        end
        chk(name, 32'(n), 32'(exp_edges));
    endtask

    task automatic wait_count(input logic [31:0] target, input string name);
        int n;
        n = 0;
        Addr = A(0, 2);
        #1;
        while (Dout !== target && n < 60) begin
            idle(A(0, 2));
            n++;
        end
        chk(name, Dout, target);
    endtask

    always @(negedge clk) begin
        logic [33:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_dout", Dout, e[31:0]);
            chk("sb_irq", 32'(IRQ), 32'(e[33:32]));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ch, rg;
        logic [29:0] a;
        logic [31:0] d;
        for (int c = 0; c < N_CH; c++) begin
            m_ctrl[c] = 0; m_preset[c] = 0; m_count[c] = 0; m_pend[c] = 0; m_ph[c] = PH_IDLE;
        end
        reset = 1'b1; WE = 1'b0; Addr = '0; Din = '0; byteen = '0;
        @(posedge clk);
        m_edge();
        #1;
        reset = 1'b0;
        rd_chk("reset_ctrl0", A(0, 0), 32'h0);
        chk("reset_irq", 32'(IRQ), 32'h0);

        // one-shot, IM set
        wr(A(0, 1), 32'd5);
        wr(A(0, 0), 32'h9);
        wait_rise(0, 6, "oneshot_latency");
        idle(A(0, 0));
        idle(A(0, 0));
        rd_chk("oneshot_ctrl_after", A(0, 0), 32'h8);
        wr(A(0, 3), 32'h1);
        chk("oneshot_w1c_irq", 32'(IRQ[0]), 32'h0);

        // auto-reload with W1C between expiries, then W1C colliding with a set
        wr(A(1, 1), 32'd3);
        wr(A(1, 0), 32'hB);
        wait_rise(1, 4, "reload_first");
        wr(A(1, 3), 32'h1);
        chk("reload_w1c_drop", 32'(IRQ[1]), 32'h0);
        wait_rise(1, 4, "reload_period");
        wr(A(1, 3), 32'h1);
        idle(A(1, 3));
        idle(A(1, 3));
        idle(A(1, 3));
        wr(A(1, 3), 32'h1);
        chk("w1c_vs_set", 32'(IRQ[1]), 32'h1);
        wr(A(1, 0), 32'h3);
        chk("im0_irq", 32'(IRQ[1]), 32'h0);
        rd_chk("im0_pending", A(1, 3), 32'h1);
        wr(A(1, 0), 32'h0);
        idle(A(1, 0));
        wr(A(1, 3), 32'h1);

        // byte enables, read-only COUNT, out-of-range channel, ignored high address bits
        wr(A(0, 1), 32'h11223344);
        wr(A(0, 1), 32'h0000AB00, 4'b0010);
        rd_chk("byteen_merge", A(0, 1), 32'h1122AB44);
        wr(A(0, 2), 32'h0000FFFF);
        rd_chk("count_ro", A(0, 2), 32'h0);
        rd_chk("ch_out_of_range", A(N_CH, 1), 32'h0);
        idle(A(0, 1));
        rd_chk("addr_high_ignored", 30'h100 | A(0, 1), 32'h1122AB44);
        wr(A(N_CH, 1), 32'hDEADBEEF);

        // PRESET 0 and 1 both expire two edges after enable
        wr(A(0, 1), 32'd0);
        wr(A(0, 0), 32'h9);
        wait_rise(0, 2, "preset0_latency");
        wr(A(0, 3), 32'h1);
        wr(A(0, 1), 32'd1);
        wr(A(0, 0), 32'h9);
        wait_rise(0, 2, "preset1_latency");
        wr(A(0, 3), 32'h1);

        // EN cleared while counting freezes COUNT
        wr(A(0, 1), 32'd20);
        wr(A(0, 0), 32'h9);
        wait_count(32'd7, "reach_count7");
        wr(A(0, 0), 32'h8);
        repeat (5) idle(A(0, 2));
        rd_chk("en_clear_hold", A(0, 2), 32'd7);
        chk("en_clear_noirq", 32'(IRQ[0]), 32'h0);

        // reset mid-count
        wr(A(0, 1), 32'd10);
        wr(A(0, 0), 32'h9);
        wait_count(32'd4, "reach_count4");
        reset = 1'b1;
        idle(A(0, 2));
        reset = 1'b0;
        rd_chk("rst_count", A(0, 2), 32'h0);
        rd_chk("rst_ctrl", A(0, 0), 32'h0);
        chk("rst_irq", 32'(IRQ), 32'h0);
        repeat (15) idle(A(0, 3));

        // random register traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) < 2);
            ch = ($urandom_range(0, 9) == 0) ? $urandom_range(2, 3) : $urandom_range(0, 1);
            rg = $urandom_range(0, 3);
            a  = 30'(ch * 4 + rg);
            if ($urandom_range(0, 7) == 0) a = a | (30'($urandom) & 30'h3FFFFFF0);
            case (rg)
                1:       d = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 12));
                default: d = $urandom;
            endcase
            Addr   = a;
            WE     = ($urandom_range(0, 2) == 0);
            Din    = d;
            byteen = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            step();
        end
        reset = 1'b0; WE = 1'b0; Din = '0; byteen = '0;
        idle(A(0, 0));
        idle(A(1, 3));
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
